// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU ops, FSM states
// and accumulator source encodings.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_XOR   = 4'h3,
    OP_SFL   = 4'h4,
    OP_SFR   = 4'h5,
    OP_CMP   = 4'h6,
    OP_GTR   = 4'h7,
    OP_STORE = 4'h8,
    OP_PUT   = 4'h9,
    OP_BTR   = 4'hA,
    OP_JMP   = 4'hB,
    OP_LB    = 4'hC,
    OP_SB    = 4'hD,
    OP_RSVD  = 4'hE,
    OP_HALT  = 4'hF
  } instr_o_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_SFL = 3'd4,
    ALU_SFR = 3'd5,
    ALU_EQU = 3'd6,
    ALU_GTR = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } ctrl_state_t;

  localparam logic [1:0] ACC_SRC_IMM = 2'b00;
  localparam logic [1:0] ACC_SRC_REG = 2'b01;
  localparam logic [1:0] ACC_SRC_MEM = 2'b10;
  localparam logic [1:0] ACC_SRC_ALU = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller-side bundle: fetch handshake, decoded control strobes and status.
interface multicycle_controller_if #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  import multicycle_controller_pkg::*;

  logic            start;
  logic            fetch_ack;
  logic            TYP;
  logic [OP_W-1:0] OP;

  logic             fetch_req;
  logic             br_ctrl;
  logic             jmp_ctrl;
  logic             regwrite_ctrl;
  alu_op_t          aluop_ctrl;
  logic             memwrite_ctrl;
  logic             mem_req;
  logic [1:0]       accdata_ctrl;
  logic             accwrite_ctrl;
  logic             pc_en;
  logic             illegal;
  logic             done;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, fetch_ack, TYP, OP,
    output fetch_req, br_ctrl, jmp_ctrl, regwrite_ctrl, aluop_ctrl, memwrite_ctrl,
           mem_req, accdata_ctrl, accwrite_ctrl, pc_en, illegal, done, retired
  );

  modport slave (
    output start, fetch_ack, TYP, OP,
    input  fetch_req, br_ctrl, jmp_ctrl, regwrite_ctrl, aluop_ctrl, memwrite_ctrl,
           mem_req, accdata_ctrl, accwrite_ctrl, pc_en, illegal, done, retired
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that times data-memory accesses; zero marks the final cycle.
module mem_wait_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int CW = 4;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/multicycle_controller.sv
// Fetch/execute/memory-wait sequencer for the accumulator datapath. Controls are
// Moore outputs decoded from the state and the latched instruction only.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    CLK,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_FETCH = S_FETCH;
  localparam logic [2:0] ST_EXEC  = S_EXEC;
  localparam logic [2:0] ST_MEM   = S_MEM;
  localparam logic [2:0] ST_DONE  = S_DONE;

  logic [2:0]       state, state_nxt;
  logic             typ_r;
  logic [OP_W-1:0]  op_r;
  logic [CNT_W-1:0] retired_r;
  logic             timer_load, timer_zero;
  logic             pc_en_c, alu_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  mem_wait_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk  (CLK),
    .rst  (reset),
    .load (timer_load),
    .zero (timer_zero)
  );

  always_comb begin
    state_nxt         = state;
    timer_load        = 1'b0;
    pc_en_c           = 1'b0;
    alu_sel           = 1'b0;
    bus.fetch_req     = 1'b0;
    bus.br_ctrl       = 1'b0;
    bus.jmp_ctrl      = 1'b0;
    bus.regwrite_ctrl = 1'b0;
    bus.aluop_ctrl    = ALU_ADD;
    bus.memwrite_ctrl = 1'b0;
    bus.mem_req       = 1'b0;
    bus.accdata_ctrl  = ACC_SRC_IMM;
    bus.accwrite_ctrl = 1'b0;
    bus.illegal       = 1'b0;
    bus.done          = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_FETCH;
      ST_FETCH: begin
        bus.fetch_req = 1'b1;
        if (bus.fetch_ack) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        pc_en_c   = 1'b1;
        if (typ_r) begin
          bus.accwrite_ctrl = 1'b1;
          bus.accdata_ctrl  = ACC_SRC_IMM;
        end else begin
          case (op_r)
            OP_W'(OP_ADD):   begin alu_sel = 1'b1; bus.aluop_ctrl = ALU_ADD; end
            OP_W'(OP_SUB):   begin alu_sel = 1'b1; bus.aluop_ctrl = ALU_SUB; end
            OP_W'(OP_AND):   begin alu_sel = 1'b1; bus.aluop_ctrl = ALU_AND; end
            OP_W'(OP_XOR):   begin alu_sel = 1'b1; bus.aluop_ctrl = ALU_XOR; end
            OP_W'(OP_SFL):   begin alu_sel = 1'b1; bus.aluop_ctrl = ALU_SFL; end
            OP_W'(OP_SFR):   begin alu_sel = 1'b1; bus.aluop_ctrl = ALU_SFR; end
            OP_W'(OP_CMP):   begin alu_sel = 1'b1; bus.aluop_ctrl = ALU_EQU; end
            OP_W'(OP_GTR):   begin alu_sel = 1'b1; bus.aluop_ctrl = ALU_GTR; end
            // STORE deliberately leaves the accumulator untouched
            OP_W'(OP_STORE): bus.regwrite_ctrl = 1'b1;
            OP_W'(OP_PUT): begin
              bus.accwrite_ctrl = 1'b1;
              bus.accdata_ctrl  = ACC_SRC_REG;
            end
            OP_W'(OP_BTR):   bus.br_ctrl  = 1'b1;
            OP_W'(OP_JMP):   bus.jmp_ctrl = 1'b1;
            OP_W'(OP_LB), OP_W'(OP_SB): begin
              pc_en_c    = 1'b0;
              timer_load = 1'b1;
              state_nxt  = ST_MEM;
            end
            OP_W'(OP_HALT): begin
              pc_en_c   = 1'b0;
              state_nxt = ST_DONE;
            end
            default:         bus.illegal = 1'b1;
          endcase
          if (alu_sel) begin
            bus.accwrite_ctrl = 1'b1;
            bus.accdata_ctrl  = ACC_SRC_ALU;
          end
        end
      end
      ST_MEM: begin
        bus.mem_req = 1'b1;
        if (timer_zero) begin
          pc_en_c   = 1'b1;
          state_nxt = ST_FETCH;
          if (op_r == OP_W'(OP_SB)) begin
            bus.memwrite_ctrl = 1'b1;
          end else begin
            bus.accwrite_ctrl = 1'b1;
            bus.accdata_ctrl  = ACC_SRC_MEM;
          end
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        if (bus.start) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.pc_en   = pc_en_c;
  assign bus.retired = retired_r;

  // state, instruction register and retire counter advance on the clock edge
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      typ_r     <= 1'b0;
      op_r      <= '0;
      retired_r <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && bus.fetch_ack) begin
        typ_r <= bus.TYP;
        op_r  <= bus.OP;
      end
      if (state == ST_DONE && bus.start) begin
        retired_r <= '0;
      end else if (pc_en_c) begin
        retired_r <= sat_inc(retired_r);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked cycle by cycle against a behavioural model.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  localparam int OP_W    = 4;
  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 16;
  localparam int CNT2_W  = 2;
  localparam int RET_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OP_W(OP_W), .CNT_W(CNT_W))  bus ();
  multicycle_controller_if #(.OP_W(OP_W), .CNT_W(CNT2_W)) bus2 ();

  multicycle_controller #(.OP_W(OP_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .CLK(clk), .reset(reset), .bus(bus)
  );
  multicycle_controller #(.OP_W(OP_W), .MEM_LAT(1), .CNT_W(CNT2_W)) dut2 (
    .CLK(clk), .reset(reset), .bus(bus2)
  );

  typedef struct packed {
    logic       fetch_req;
    logic       br;
    logic       jmp;
    logic       regwrite;
    logic [2:0] aluop;
    logic       memwrite;
    logic       mem_req;
    logic [1:0] accdata;
    logic       accwrite;
    logic       pc_en;
    logic       illegal;
    logic       done;
  } ctrl_t;

  typedef struct packed {
    int cyc; int nfr; int nreq; int nwr; int nacc; int npc; int nill; int nreg;
  } cnt_t;

  int n_checks = 0;
  int n_fail   = 0;
  int ret_m    = 0;

  function automatic ctrl_t obs();
    ctrl_t o;
    o.fetch_req = bus.fetch_req;     o.br       = bus.br_ctrl;
    o.jmp       = bus.jmp_ctrl;      o.regwrite = bus.regwrite_ctrl;
    o.aluop     = bus.aluop_ctrl;    o.memwrite = bus.memwrite_ctrl;
    o.mem_req   = bus.mem_req;       o.accdata  = bus.accdata_ctrl;
    o.accwrite  = bus.accwrite_ctrl; o.pc_en    = bus.pc_en;
    o.illegal   = bus.illegal;       o.done     = bus.done;
    return o;
  endfunction

  // What the execute cycle of one instruction must look like
  function automatic ctrl_t exp_exec(input logic typ, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    if (typ) begin
      c.accwrite = 1'b1; c.accdata = ACC_SRC_IMM; c.pc_en = 1'b1;
      return c;
    end
    case (op)
      OP_ADD:   c.aluop = ALU_ADD;
      OP_SUB:   c.aluop = ALU_SUB;
      OP_AND:   c.aluop = ALU_AND;
      OP_XOR:   c.aluop = ALU_XOR;
      OP_SFL:   c.aluop = ALU_SFL;
      OP_SFR:   c.aluop = ALU_SFR;
      OP_CMP:   c.aluop = ALU_EQU;
      OP_GTR:   c.aluop = ALU_GTR;
      OP_STORE: c.regwrite = 1'b1;
      OP_PUT:   begin c.accwrite = 1'b1; c.accdata = ACC_SRC_REG; end
      OP_BTR:   c.br = 1'b1;
      OP_JMP:   c.jmp = 1'b1;
      OP_RSVD:  c.illegal = 1'b1;
      default:  ;
    endcase
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SFL, OP_SFR, OP_CMP, OP_GTR}) begin
      c.accwrite = 1'b1; c.accdata = ACC_SRC_ALU;
    end
    c.pc_en = !(op inside {OP_LB, OP_SB, OP_HALT});
    return c;
  endfunction

  function automatic int sat(input int v);
    return (v > RET_MAX) ? RET_MAX : v;
  endfunction

  function automatic cnt_t tally(input cnt_t n, input ctrl_t o);
    cnt_t r;
    r = n;
    r.cyc++; r.nfr += int'(o.fetch_req); r.nreq += int'(o.mem_req);
    r.nwr += int'(o.memwrite); r.nacc += int'(o.accwrite); r.npc += int'(o.pc_en);
    r.nill += int'(o.illegal); r.nreg += int'(o.regwrite);
    return r;
  endfunction

  task automatic drive_junk();
    bus.fetch_ack = 1'($urandom);
    bus.TYP       = 1'($urandom);
    bus.OP        = 4'($urandom);
    bus.start     = 1'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.fetch_ack = 1'b0; bus.TYP = 1'b0; bus.OP = '0;
    @(negedge clk);
    reset = 1'b0;
    ret_m = 0;
  endtask

  task automatic kick();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs one instruction from FETCH, comparing every cycle with the model
  task automatic run_instr(input logic typ, input logic [3:0] op, input int delay,
                           input string tag, output cnt_t n);
    ctrl_t e, o;
    n = '0;
    for (int d = 0; d <= delay; d++) begin
      e = '0; e.fetch_req = 1'b1; o = obs(); n_checks++;
      if (o !== e || bus.retired !== CNT_W'(ret_m)) begin
        n_fail++;
        $display("FAIL %s fetch%0d: got ctrl=%h retired=%0d, want ctrl=%h retired=%0d",
                 tag, d, o, bus.retired, e, ret_m);
      end
      n = tally(n, o);
      drive_junk();
      bus.fetch_ack = (d == delay);
      if (d == delay) begin bus.TYP = typ; bus.OP = op; end
      @(negedge clk);
    end
    e = exp_exec(typ, op); o = obs(); n_checks++;
    if (o !== e || bus.retired !== CNT_W'(ret_m)) begin
      n_fail++;
      $display("FAIL %s exec: got ctrl=%h retired=%0d, want ctrl=%h retired=%0d",
               tag, o, bus.retired, e, ret_m);
    end
    n = tally(n, o);
    drive_junk();
    if (e.pc_en) ret_m = sat(ret_m + 1);
    @(negedge clk);
    if (!typ && (op == OP_LB || op == OP_SB)) begin
      for (int k = 1; k <= MEM_LAT; k++) begin
        e = '0; e.mem_req = 1'b1;
        if (k == MEM_LAT) begin
          e.pc_en = 1'b1;
          if (op == OP_SB) e.memwrite = 1'b1;
          else begin e.accwrite = 1'b1; e.accdata = ACC_SRC_MEM; end
        end
        o = obs(); n_checks++;
        if (o !== e || bus.retired !== CNT_W'(ret_m)) begin
          n_fail++;
          $display("FAIL %s mem%0d: got ctrl=%h retired=%0d, want ctrl=%h retired=%0d",
                   tag, k, o, bus.retired, e, ret_m);
        end
        n = tally(n, o);
        drive_junk();
        if (e.pc_en) ret_m = sat(ret_m + 1);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1; bus.fetch_ack = 1'b1; bus.TYP = 1'b0; bus.OP = OP_ADD;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs() !== ctrl_t'(0) || bus.retired !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ctrl=%h retired=%0d, want ctrl=0 retired=0", obs(), bus.retired);
    end
    n_checks++;
    if (bus2.retired !== '0 || bus2.done !== 1'b0 || bus2.fetch_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state2: got retired=%0d done=%b fetch_req=%b, want 0 0 0",
               bus2.retired, bus2.done, bus2.fetch_req);
    end
    reset = 1'b0; bus.start = 1'b0; bus.fetch_ack = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    bus.start = 1'b1; bus.fetch_ack = 1'b1; bus.TYP = 1'b0; bus.OP = OP_ADD;
    @(negedge clk);
    n_checks++;
    if (bus.fetch_req !== 1'b1 || bus.pc_en !== 1'b0 || bus.accwrite_ctrl !== 1'b0) begin
      n_fail++;
      $display("FAIL add_fetch: got fetch_req=%b pc_en=%b accwrite=%b, want 1 0 0",
               bus.fetch_req, bus.pc_en, bus.accwrite_ctrl);
    end
    @(negedge clk);
    n_checks++;
    if (bus.accwrite_ctrl !== 1'b1 || bus.accdata_ctrl !== 2'b11 || bus.aluop_ctrl !== ALU_ADD ||
        bus.pc_en !== 1'b1 || bus.retired !== 16'd0) begin
      n_fail++;
      $display("FAIL add_exec: got accwrite=%b accdata=%b aluop=%0d pc_en=%b retired=%0d, want 1 11 0 1 0",
               bus.accwrite_ctrl, bus.accdata_ctrl, bus.aluop_ctrl, bus.pc_en, bus.retired);
    end
    @(negedge clk);
    n_checks++;
    if (bus.retired !== 16'd1) begin
      n_fail++;
      $display("FAIL add_retired: got %0d, want 1", bus.retired);
    end
    bus.start = 1'b0; bus.fetch_ack = 1'b0;
  endtask

  task automatic test_mem();
    cnt_t n;
    do_reset(); kick();
    run_instr(1'b0, OP_SB, 0, "sb", n);
    n_checks++;
    if (n.nreq != 3 || n.nwr != 1 || n.npc != 1 || n.nacc != 0 || n.cyc != 5) begin
      n_fail++;
      $display("FAIL sb_counts: got mem_req=%0d memwrite=%0d pc_en=%0d accwrite=%0d cycles=%0d, want 3 1 1 0 5",
               n.nreq, n.nwr, n.npc, n.nacc, n.cyc);
    end
    run_instr(1'b0, OP_LB, 0, "lb", n);
    n_checks++;
    if (n.nreq != 3 || n.nwr != 0 || n.npc != 1 || n.nacc != 1 || n.cyc != 5) begin
      n_fail++;
      $display("FAIL lb_counts: got mem_req=%0d memwrite=%0d pc_en=%0d accwrite=%0d cycles=%0d, want 3 0 1 1 5",
               n.nreq, n.nwr, n.npc, n.nacc, n.cyc);
    end
    n_checks++;
    if (bus.retired !== 16'd2) begin
      n_fail++;
      $display("FAIL mem_retired: got %0d, want 2", bus.retired);
    end
  endtask

  task automatic test_fetch_stall();
    cnt_t n;
    do_reset(); kick();
    run_instr(1'b0, OP_JMP, 5, "jmp_stall", n);
    n_checks++;
    if (n.nfr != 6 || n.cyc != 7 || n.npc != 1) begin
      n_fail++;
      $display("FAIL stall_counts: got fetch_req=%0d cycles=%0d pc_en=%0d, want 6 7 1", n.nfr, n.cyc, n.npc);
    end
  endtask

  task automatic test_stream();
    cnt_t n;
    do_reset(); kick();
    run_instr(1'b1, 4'($urandom), 0, "imm", n);
    n_checks++;
    if (n.nacc != 1 || n.nreg != 0) begin
      n_fail++;
      $display("FAIL imm_counts: got accwrite=%0d regwrite=%0d, want 1 0", n.nacc, n.nreg);
    end
    run_instr(1'b0, OP_STORE, 0, "store", n);
    n_checks++;
    if (n.nreg != 1 || n.nacc != 0) begin
      n_fail++;
      $display("FAIL store_counts: got regwrite=%0d accwrite=%0d, want 1 0", n.nreg, n.nacc);
    end
    run_instr(1'b0, OP_RSVD, 0, "rsvd", n);
    n_checks++;
    if (n.nill != 1 || n.npc != 1) begin
      n_fail++;
      $display("FAIL rsvd_counts: got illegal=%0d pc_en=%0d, want 1 1", n.nill, n.npc);
    end
    run_instr(1'b0, OP_HALT, 0, "halt", n);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus.done !== 1'b1 || bus.retired !== 16'd3 || bus.fetch_req !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_done%0d: got done=%b retired=%0d fetch_req=%b, want 1 3 0",
                 i, bus.done, bus.retired, bus.fetch_req);
      end
      @(negedge clk);
    end
    kick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.retired !== 16'd0 || bus.fetch_req !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: got done=%b retired=%0d fetch_req=%b, want 0 0 1",
               bus.done, bus.retired, bus.fetch_req);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset(); kick();
    bus.fetch_ack = 1'b1; bus.TYP = 1'b0; bus.OP = OP_SB;
    @(negedge clk);
    bus.fetch_ack = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 2; k++) begin
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.memwrite_ctrl !== 1'b0) begin
        n_fail++;
        $display("FAIL midmem%0d: got mem_req=%b memwrite=%b, want 1 0", k, bus.mem_req, bus.memwrite_ctrl);
      end
      if (k == 2) reset = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs() !== ctrl_t'(0) || bus.retired !== 16'd0) begin
        n_fail++;
        $display("FAIL post_reset%0d: got ctrl=%h retired=%0d, want ctrl=0 retired=0", i, obs(), bus.retired);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    int exp_r;
    do_reset();
    bus2.start = 1'b1; bus2.fetch_ack = 1'b1; bus2.TYP = 1'b0; bus2.OP = OP_PUT;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      exp_r = (k > 3) ? 3 : k;
      n_checks++;
      if (bus2.retired !== CNT2_W'(exp_r) || bus2.fetch_req !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_retired%0d: got retired=%0d fetch_req=%b, want %0d 1",
                 k, bus2.retired, bus2.fetch_req, exp_r);
      end
      @(negedge clk);
      n_checks++;
      if (bus2.pc_en !== 1'b1 || bus2.accwrite_ctrl !== 1'b1 || bus2.accdata_ctrl !== 2'b01) begin
        n_fail++;
        $display("FAIL sat_put%0d: got pc_en=%b accwrite=%b accdata=%b, want 1 1 01",
                 k, bus2.pc_en, bus2.accwrite_ctrl, bus2.accdata_ctrl);
      end
      @(negedge clk);
    end
    bus2.start = 1'b0; bus2.fetch_ack = 1'b0;
  endtask

  task automatic test_random();
    cnt_t n;
    logic typ;
    logic [3:0] op;
    do_reset(); kick();
    for (int i = 0; i < 80; i++) begin
      typ = ($urandom_range(0, 5) == 0);
      op  = 4'($urandom);
      run_instr(typ, op, $urandom_range(0, 2), "rand", n);
      if (!typ && op == OP_HALT) begin
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.pc_en !== 1'b0 || bus.retired !== CNT_W'(ret_m)) begin
          n_fail++;
          $display("FAIL rand_halt%0d: got done=%b pc_en=%b retired=%0d, want 1 0 %0d",
                   i, bus.done, bus.pc_en, bus.retired, ret_m);
        end
        kick();
        ret_m = 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.fetch_ack = 1'b0; bus.TYP = 1'b0; bus.OP = '0;
    bus2.start = 1'b0; bus2.fetch_ack = 1'b0; bus2.TYP = 1'b0; bus2.OP = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_mem();
    test_fetch_stall();
    test_stream();
    test_reset_mid_mem();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
